rect_fill_engine: RTL and testbench



---
 rtl/rect_fill_engine.sv | 150 +++++++++++++++
 tb/tb_rect_fill_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: accepts a rectangle on the draw handshake and sweeps it
// row-major onto the VGA plot port, one pixel per clock, then pulses done.
module rect_fill_engine #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3,
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119,
    parameter int MAX_DIM = 16
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           req,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [4:0]     w,
    input  logic [4:0]     h,
    input  logic [C_W-1:0] fill_color,
    input  logic           border_en,
    input  logic [C_W-1:0] border_color,
    input  logic           abort,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_color,
    output logic           vga_plot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [X_W-1:0] x0_q;
    logic [Y_W-1:0] y0_q;
    logic [C_W-1:0] fill_q;
    logic [C_W-1:0] border_q;
    logic           border_en_q;
    logic [4:0]     w_q;
    logic [4:0]     h_q;
    logic [4:0]     xc;
    logic [4:0]     yc;

    logic [4:0]     w_clamped;
    logic [4:0]     h_clamped;
    logic           accept;
    logic           last_col;
    logic           last_row;
    logic           on_edge;
    logic           in_view;
    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y;

    function automatic logic [4:0] clamp_dim(input logic [4:0] d);
        if (d > 5'(MAX_DIM))
            return 5'(MAX_DIM);
        return d;
    endfunction

    assign w_clamped = clamp_dim(w);
    assign h_clamped = clamp_dim(h);

    assign last_col = (xc == w_q - 5'd1);
    assign last_row = (yc == h_q - 5'd1);
    assign on_edge  = (xc == 5'd0) || (yc == 5'd0) || last_col || last_row;

    // One extra bit so positions past the screen edge are detected, not wrapped.
    assign sum_x   = {1'b0, x0_q} + (X_W+1)'(xc);
    assign sum_y   = {1'b0, y0_q} + (Y_W+1)'(yc);
    assign in_view = (sum_x <= (X_W+1)'(X_MAX)) && (sum_y <= (Y_W+1)'(Y_MAX));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req && !abort) begin
                    accept    = 1'b1;
                    state_nxt = (w_clamped == 5'd0 || h_clamped == 5'd0) ? FIN : FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (abort)
                    state_nxt = IDLE;
                else if (last_col && last_row)
                    state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_q        <= '0;
            y0_q        <= '0;
            fill_q      <= '0;
            border_q    <= '0;
            border_en_q <= 1'b0;
            w_q         <= '0;
            h_q         <= '0;
            xc          <= '0;
            yc          <= '0;
        end else if (accept) begin
            x0_q        <= x0;
            y0_q        <= y0;
            fill_q      <= fill_color;
            border_q    <= border_color;
            border_en_q <= border_en;
            w_q         <= w_clamped;
            h_q         <= h_clamped;
            xc          <= '0;
            yc          <= '0;
        end else if (state == FILL && !abort) begin
            if (last_col) begin
                xc <= '0;
                yc <= last_row ? 5'd0 : yc + 5'd1;
            end else begin
                xc <= xc + 5'd1;
            end
        end
    end

    // Pixel port is quiet outside FILL; clipped cycles show colour 0.
    assign vga_plot  = busy && in_view;
    assign vga_x     = busy ? sum_x[X_W-1:0] : '0;
    assign vga_y     = busy ? sum_y[Y_W-1:0] : '0;
    assign vga_color = !vga_plot ? '0 : ((border_en_q && on_edge) ? border_q : fill_q);

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed scenarios plus random rectangles checked
// against a per-pixel model derived from the rectangle geometry.
module tb_rect_fill_engine;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] fill_color;
    logic       border_en;
    logic [2:0] border_color;
    logic       abort;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_color;
    logic       vga_plot;

    int errors = 0;
    int checks = 0;

    rect_fill_engine dut (
        .clk(clk), .resetn(resetn), .req(req), .x0(x0), .y0(y0), .w(w), .h(h),
        .fill_color(fill_color), .border_en(border_en), .border_color(border_color),
        .abort(abort), .ready(ready), .busy(busy), .done(done), .vga_x(vga_x),
        .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [7:0] ax, input logic [6:0] ay, input logic [4:0] aw,
                           input logic [4:0] ah, input logic [2:0] fc, input logic be,
                           input logic [2:0] bc);
        x0 = ax; y0 = ay; w = aw; h = ah;
        fill_color = fc; border_en = be; border_color = bc;
    endtask

    // Called on the first cycle after acceptance; walks every pixel, the done cycle
    // and the following idle cycle. Operand inputs may be scrambled meanwhile.
    task automatic expect_sweep(input logic [7:0] ex0, input logic [6:0] ey0, input logic [4:0] ew,
                                input logic [4:0] eh, input logic [2:0] efc, input logic ebe,
                                input logic [2:0] ebc, input bit scramble, input string tag);
        int wc, hc, n, col, row, ax, ay;
        logic vis, edge_px;
        logic [2:0] ecol;
        logic [21:0] obs, exp_v;
        wc = (ew > 16) ? 16 : int'(ew);
        hc = (eh > 16) ? 16 : int'(eh);
        n  = wc * hc;
        for (int i = 0; i < n; i++) begin
            col = i % wc;
            row = i / wc;
            ax  = int'(ex0) + col;
            ay  = int'(ey0) + row;
            vis = (ax <= 159) && (ay <= 119);
            edge_px = (col == 0) || (row == 0) || (col == wc - 1) || (row == hc - 1);
            ecol = !vis ? 3'd0 : ((ebe && edge_px) ? ebc : efc);
            exp_v = {vis, 8'(ax), 7'(ay), ecol, 3'b100};
            obs   = {vga_plot, vga_x, vga_y, vga_color, busy, ready, done};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s pixel %0d: got %h want %h", tag, i, obs, exp_v);
            end
            if (scramble) begin
                x0 = 8'($urandom); y0 = 7'($urandom); w = 5'($urandom); h = 5'($urandom);
                fill_color = 3'($urandom); border_en = 1'($urandom); border_color = 3'($urandom);
            end
            tick();
        end
        obs = {vga_plot, vga_x, vga_y, vga_color, busy, ready, done};
        checks++;
        if (obs !== 22'b001) begin
            errors++;
            $display("FAIL %s done-cycle: got %h want %h", tag, obs, 22'b001);
        end
        tick();
        obs = {vga_plot, vga_x, vga_y, vga_color, busy, ready, done};
        checks++;
        if (obs !== 22'b010) begin
            errors++;
            $display("FAIL %s ready-cycle: got %h want %h", tag, obs, 22'b010);
        end
    endtask

    task automatic start(input bit hold);
        req = 1'b1;
        tick();
        if (!hold) req = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0; abort = 1'b0;
        set_ops(8'd0, 7'd0, 5'd0, 5'd0, 3'd0, 1'b0, 3'd0);
        #12;
        checks++;
        if ({ready, busy, done, vga_plot, vga_x, vga_y, vga_color} !== {4'b1000, 18'd0}) begin
            errors++;
            $display("FAIL reset-state: got %b%b%b%b", ready, busy, done, vga_plot);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        checks++;
        if ({ready, busy, done, vga_plot} !== 4'b1000) begin
            errors++;
            $display("FAIL post-reset idle: got %b%b%b%b want 1000", ready, busy, done, vga_plot);
        end
    endtask

    task automatic test_ball_outline();
        set_ops(8'd80, 7'd60, 5'd4, 5'd4, 3'd5, 1'b1, 3'd0);
        start(1'b0);
        expect_sweep(8'd80, 7'd60, 5'd4, 5'd4, 3'd5, 1'b1, 3'd0, 1'b0, "ball");
    endtask

    task automatic test_clipping();
        set_ops(8'd158, 7'd118, 5'd4, 5'd4, 3'd7, 1'b0, 3'd2);
        start(1'b0);
        expect_sweep(8'd158, 7'd118, 5'd4, 5'd4, 3'd7, 1'b0, 3'd2, 1'b0, "clip");
    endtask

    task automatic test_empty_and_clamp();
        set_ops(8'd10, 7'd10, 5'd0, 5'd5, 3'd3, 1'b0, 3'd0);
        start(1'b0);
        expect_sweep(8'd10, 7'd10, 5'd0, 5'd5, 3'd3, 1'b0, 3'd0, 1'b0, "empty");
        set_ops(8'd0, 7'd5, 5'd20, 5'd1, 3'd6, 1'b1, 3'd1);
        start(1'b0);
        expect_sweep(8'd0, 7'd5, 5'd20, 5'd1, 3'd6, 1'b1, 3'd1, 1'b0, "clamp");
    endtask

    task automatic test_abort();
        set_ops(8'd20, 7'd30, 5'd4, 5'd4, 3'd2, 1'b0, 3'd0);
        start(1'b0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd21, 7'd31}) begin
            errors++;
            $display("FAIL abort 6th-pixel: got %b %0d %0d want 1 21 31", vga_plot, vga_x, vga_y);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({vga_plot, ready, busy, done} !== 4'b0100) begin
            errors++;
            $display("FAIL abort-idle: got %b%b%b%b want 0100", vga_plot, ready, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL abort-no-done: got done=%b busy=%b want 00", done, busy);
            end
        end
        req = 1'b1; abort = 1'b1;
        tick();
        req = 1'b0; abort = 1'b0;
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL abort-over-req: got %b%b%b want 100", ready, busy, done);
        end
        set_ops(8'd40, 7'd40, 5'd3, 5'd2, 3'd4, 1'b1, 3'd7);
        start(1'b0);
        expect_sweep(8'd40, 7'd40, 5'd3, 5'd2, 3'd4, 1'b1, 3'd7, 1'b0, "after-abort");
    endtask

    task automatic test_back_to_back();
        set_ops(8'd5, 7'd6, 5'd3, 5'd3, 3'd1, 1'b1, 3'd6);
        start(1'b1);
        expect_sweep(8'd5, 7'd6, 5'd3, 5'd3, 3'd1, 1'b1, 3'd6, 1'b0, "b2b-first");
        set_ops(8'd100, 7'd50, 5'd2, 5'd4, 3'd3, 1'b0, 3'd0);
        tick();
        req = 1'b0;
        expect_sweep(8'd100, 7'd50, 5'd2, 5'd4, 3'd3, 1'b0, 3'd0, 1'b0, "b2b-second");
    endtask

    task automatic test_reset_mid_sweep();
        set_ops(8'd60, 7'd60, 5'd8, 5'd8, 3'd5, 1'b1, 3'd2);
        start(1'b0);
        for (int i = 0; i < 3; i++) tick();
        resetn = 1'b0;
        #1;
        checks++;
        if ({ready, busy, done, vga_plot, vga_x, vga_y, vga_color} !== {4'b1000, 18'd0}) begin
            errors++;
            $display("FAIL reset-mid-sweep async: got %b%b%b%b x=%0d", ready, busy, done, vga_plot, vga_x);
        end
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ready, busy, done, vga_plot, vga_x, vga_y, vga_color} !== {4'b1000, 18'd0}) begin
                errors++;
                $display("FAIL reset-release idle: got %b%b%b%b", ready, busy, done, vga_plot);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] rx; logic [6:0] ry; logic [4:0] rw, rh; logic [2:0] rf, rb; logic re;
        for (int k = 0; k < 25; k++) begin
            rx = (k % 3 == 0) ? 8'($urandom) : 8'($urandom_range(140, 165));
            ry = (k % 2 == 0) ? 7'($urandom) : 7'($urandom_range(100, 127));
            rw = 5'($urandom); rh = 5'($urandom);
            rf = 3'($urandom); rb = 3'($urandom); re = 1'($urandom);
            set_ops(rx, ry, rw, rh, rf, re, rb);
            start(1'b0);
            expect_sweep(rx, ry, rw, rh, rf, re, rb, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_ball_outline();
        test_clipping();
        test_empty_and_clamp();
        test_abort();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
